// File: rtl/ring_decoder.sv
// Observes an N-bit one-hot ring counter, reports the position of the set bit,
// counts laps and latches the first sequencing fault until it is cleared.
module ring_decoder #(
    parameter int N = 4,
    parameter int C = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    input  logic [N-1:0] q,
    input  logic         clr_err,
    output logic [W-1:0] idx,
    output logic         valid,
    output logic         wrap,
    output logic [C-1:0] lap_cnt,
    output logic [1:0]   err_code
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        FAULT
    } state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   q_prev;
    logic           adv_prev;
    logic [N-1:0]   expected;
    logic [W-1:0]   q_index;
    logic           multi;
    logic           zero;
    logic           seq;
    logic           accept;
    logic           wrap_nxt;
    logic [1:0]     err_nxt;

    // The ring either advanced last cycle (expect the rotated value) or held.
    always_comb begin
        expected = q_prev;
        if (adv_prev) begin
            if (q_prev == '0) begin
                expected = ONE;
            end else begin
                expected = {q_prev[N-2:0], q_prev[N-1]};
            end
        end
    end

    always_comb begin
        q_index = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i]) begin
                q_index = W'(i);
            end
        end
    end

    assign multi = (q & (q - ONE)) != '0;
    assign zero  = (q == '0);
    assign seq   = (q != expected);

    always_comb begin
        state_nxt = state;
        err_nxt   = err_code;
        accept    = 1'b0;
        wrap_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (multi) begin
                    state_nxt = FAULT;
                    err_nxt   = 2'b01;
                end else if (!zero) begin
                    state_nxt = LOCK;
                    accept    = 1'b1;
                end
            end
            LOCK: begin
                if (multi) begin
                    state_nxt = FAULT;
                    err_nxt   = 2'b01;
                end else if (zero) begin
                    state_nxt = FAULT;
                    err_nxt   = 2'b10;
                end else if (seq) begin
                    state_nxt = FAULT;
                    err_nxt   = 2'b11;
                end else begin
                    accept   = 1'b1;
                    wrap_nxt = adv_prev && q_prev[N-1] && q[0] && !clr_err;
                end
            end
            FAULT: begin
                if (clr_err) begin
                    state_nxt = IDLE;
                    err_nxt   = 2'b00;
                end
            end
            default: begin
                state_nxt = IDLE;
                err_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A clear always wins over a coincident wrap, whatever the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_prev   <= '0;
            adv_prev <= 1'b0;
            idx      <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
            lap_cnt  <= '0;
            err_code <= 2'b00;
        end else begin
            q_prev   <= q;
            adv_prev <= adv;
            valid    <= (state_nxt == LOCK);
            wrap     <= wrap_nxt;
            err_code <= err_nxt;
            if (accept) begin
                idx <= q_index;
            end
            if (clr_err) begin
                lap_cnt <= '0;
            end else if (wrap_nxt) begin
                lap_cnt <= lap_cnt + C'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder (N=4, C=2): directed vector table,
// hand-written lap/reset sequences and a randomized run against an integer model.
module tb_ring_decoder;

    logic       clk;
    logic       reset;
    logic       adv;
    logic [3:0] q;
    logic       clr_err;
    logic [1:0] idx;
    logic       valid;
    logic       wrap;
    logic [1:0] lap_cnt;
    logic [1:0] err_code;

    int checks = 0;
    int passed = 0;

    // Behavioural model: mode 0 = waiting, 1 = tracking, 2 = faulted.
    int         m_mode;
    int         m_idx;
    int         m_lap;
    logic       m_wrap;
    logic       m_valid;
    logic [1:0] m_err;
    logic [3:0] m_qprev;
    logic       m_adv_prev;

    typedef struct {
        logic [3:0] q;
        logic       adv;
        logic       clr;
        logic       valid;
        logic [1:0] idx;
        logic       wrap;
        logic [1:0] lap;
        logic [1:0] err;
    } vec_t;

    vec_t vecs[23];

    ring_decoder #(.N(4), .C(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .adv      (adv),
        .q        (q),
        .clr_err  (clr_err),
        .idx      (idx),
        .valid    (valid),
        .wrap     (wrap),
        .lap_cnt  (lap_cnt),
        .err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bit_pos(input logic [3:0] v);
        int p;
        p = 0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) p = i;
        end
        return p;
    endfunction

    function automatic logic [7:0] dut_out();
        return {valid, idx, wrap, lap_cnt, err_code};
    endfunction

    function automatic logic [7:0] model_out();
        return {m_valid, 2'(m_idx), m_wrap, 2'(m_lap), m_err};
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_idx      = 0;
        m_lap      = 0;
        m_wrap     = 1'b0;
        m_valid    = 1'b0;
        m_err      = 2'b00;
        m_qprev    = 4'b0000;
        m_adv_prev = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] mq, input logic madv, input logic mclr);
        int         ones;
        int         code;
        logic [3:0] exp_q;
        logic       nwrap;
        ones = $countones(mq);
        if (!m_adv_prev) exp_q = m_qprev;
        else if (m_qprev == 4'b0000) exp_q = 4'b0001;
        else exp_q = 4'(1 << ((bit_pos(m_qprev) + 1) % 4));
        code  = (ones > 1) ? 1 : (ones == 0) ? 2 : (mq != exp_q) ? 3 : 0;
        nwrap = 1'b0;
        if (m_mode == 2) begin
            if (mclr) begin
                m_mode = 0;
                m_err  = 2'b00;
            end
        end else if (m_mode == 0) begin
            if (ones > 1) begin
                m_mode = 2;
                m_err  = 2'b01;
            end else if (ones == 1) begin
                m_mode = 1;
                m_idx  = bit_pos(mq);
            end
        end else begin
            if (code != 0) begin
                m_mode = 2;
                m_err  = 2'(code);
            end else begin
                m_idx = bit_pos(mq);
                nwrap = m_adv_prev && m_qprev[3] && mq[0] && !mclr;
            end
        end
        if (mclr) m_lap = 0;
        else if (nwrap) m_lap = (m_lap + 1) % 4;
        m_wrap     = nwrap;
        m_valid    = (m_mode == 1);
        m_qprev    = mq;
        m_adv_prev = madv;
    endtask

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got {valid,idx,wrap,lap,err}=%b expected %b", name, act, exp);
    endtask

    task automatic apply_stimulus(input logic [3:0] vq, input logic vadv, input logic vclr);
        q       = vq;
        adv     = vadv;
        clr_err = vclr;
        @(posedge clk);
        model_step(vq, vadv, vclr);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        q       = 4'b0000;
        adv     = 1'b0;
        clr_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", dut_out(), 8'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] lap_exp[5];
        logic [3:0] ring;
        logic [3:0] rq;
        logic       radv;
        logic       rclr;
        int         wrap_seen;

        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'b00};
        vecs[1]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'b00};
        vecs[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'b00};
        vecs[3]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 2'b00};
        vecs[4]  = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'b00};
        vecs[5]  = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'b00};
        vecs[6]  = '{4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 2'b00};
        vecs[7]  = '{4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 2'd1, 2'b00};
        vecs[8]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 2'b00};
        vecs[9]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 2'b00};
        vecs[10] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 2'b00};
        vecs[11] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 2'b00};
        vecs[12] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 2'b00};
        vecs[13] = '{4'b0100, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd1, 2'b11};
        vecs[14] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 2'b00};
        vecs[15] = '{4'b0100, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'b00};
        vecs[16] = '{4'b0110, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'b01};
        vecs[17] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'b01};
        vecs[18] = '{4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'b00};
        vecs[19] = '{4'b1000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 2'b00};
        vecs[20] = '{4'b0001, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 2'b00};
        vecs[21] = '{4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'b00};
        vecs[22] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 2'b10};

        lap_exp[0] = 2'd1;
        lap_exp[1] = 2'd2;
        lap_exp[2] = 2'd3;
        lap_exp[3] = 2'd0;
        lap_exp[4] = 2'd1;

        reset   = 1'b0;
        q       = 4'b0000;
        adv     = 1'b0;
        clr_err = 1'b0;
        #2;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            apply_stimulus(vecs[i].q, vecs[i].adv, vecs[i].clr);
            check_output($sformatf("vec%0d", i), dut_out(),
                         {vecs[i].valid, vecs[i].idx, vecs[i].wrap, vecs[i].lap, vecs[i].err});
        end

        // Five full laps with a 2-bit lap counter, then two more to reach 3.
        do_reset();
        wrap_seen = 0;
        apply_stimulus(4'b0001, 1'b1, 1'b0);
        check_output("lap_lock", dut_out(), 8'b1_00_0_00_00);
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(4'b0010, 1'b1, 1'b0);
            wrap_seen += int'(wrap);
            apply_stimulus(4'b0100, 1'b1, 1'b0);
            wrap_seen += int'(wrap);
            apply_stimulus(4'b1000, 1'b1, 1'b0);
            wrap_seen += int'(wrap);
            apply_stimulus(4'b0001, 1'b1, 1'b0);
            wrap_seen += int'(wrap);
            if (k < 5) begin
                check_output($sformatf("lap%0d", k + 1), dut_out(), {1'b1, 2'd0, 1'b1, lap_exp[k], 2'b00});
            end
            if (k == 4) begin
                check_output("wrap_count", 8'(wrap_seen), 8'd5);
            end
        end
        check_output("lap_three", dut_out(), 8'b1_00_1_11_00);

        // Asynchronous reset mid-cycle, then relock from an arbitrary position.
        apply_stimulus(4'b0010, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check_output("async_reset", dut_out(), 8'b0);
        model_reset();
        #2;
        reset = 1'b1;
        apply_stimulus(4'b0100, 1'b1, 1'b0);
        check_output("relock", dut_out(), 8'b1_10_0_00_00);

        // Randomized run: a well-behaved ring with occasional corruption and clears.
        do_reset();
        ring = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            rq   = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : ring;
            radv = ($urandom_range(0, 9) < 7);
            rclr = ($urandom_range(0, 19) == 0);
            apply_stimulus(rq, radv, rclr);
            check_output($sformatf("rand%0d", c), dut_out(), model_out());
            if (radv) ring = (ring == 4'b0000) ? 4'b0001 : {ring[2:0], ring[3]};
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
